// File: rtl/moon_collision_pkg.sv
// Purpose: shared game constants and the collision FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package moon_collision_pkg;

  // Playfield extent, shared with the sprite generators.
  localparam int MAX_X   = 384;
  localparam int MAX_Y   = 448;

  // Width of the lives counter (up to 7 lives).
  localparam int LIVES_W = 3;

  // Width of the per-frame overlap counter (saturates at 255).
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    ALIVE    = 2'd0,
    HIT_WAIT = 2'd1,
    INVULN   = 2'd2,
    DEAD     = 2'd3
  } state_t;

endpackage

// File: rtl/moon_collision_overlap_counter.sv
// Purpose: counts player/moon overlapping pixels per frame, latches the total at frame_tick.
// Latency: count updates the cycle after a qualifying pixel; overlap_last the cycle after frame_tick.
// Backpressure: none; every qualified pixel is counted (saturating at 255).
//
// Ports: clk, reset (sync, active low), pixel_tick/x/y/player_on/moon_on pixel stream,
//        frame_tick frame boundary, clear (new game), count running total, overlap_last
//        total of the last completed frame.
module moon_collision_overlap_counter #(
  parameter int MAX_X = moon_collision_pkg::MAX_X,
  parameter int MAX_Y = moon_collision_pkg::MAX_Y
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_tick,
  input  logic       frame_tick,
  input  logic       clear,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       player_on,
  input  logic       moon_on,
  output logic [7:0] count,
  output logic [7:0] overlap_last
);
  import moon_collision_pkg::*;

  localparam logic [9:0]       X_LIM   = 10'(MAX_X);
  localparam logic [9:0]       Y_LIM   = 10'(MAX_Y);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic qual;

  assign qual = pixel_tick && player_on && moon_on && (x < X_LIM) && (y < Y_LIM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count        <= '0;
      overlap_last <= '0;
    end else begin
      if (frame_tick) begin
        overlap_last <= count;
      end
      if (clear) begin
        count <= '0;
      end else if (frame_tick) begin
        // A pixel qualifying on the frame_tick cycle belongs to the new frame.
        count <= {{(CNT_W-1){1'b0}}, qual};
      end else if (qual && (count != CNT_MAX)) begin
        count <= count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/moon_collision.sv
// Purpose: turns per-frame moon/player overlap into hit requests; owns lives, invulnerability, game over.
// Latency: hit rises the cycle after the evaluating frame_tick, falls the cycle after hit_ack.
// Backpressure: hit is a level held until hit_ack; overlaps are not evaluated while a hit is pending.
//
// Ports: clk, reset (sync, active low); pixel stream pixel_tick/x/y/player_on/moon_on;
//        frame_tick; hit/hit_ack request-acknowledge; restart leaves game over;
//        lives, invuln, flash, game_over, overlap_last status.
module moon_collision #(
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int HIT_PIXELS    = 4,
  parameter int MAX_X         = moon_collision_pkg::MAX_X,
  parameter int MAX_Y         = moon_collision_pkg::MAX_Y
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_tick,
  input  logic       frame_tick,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       player_on,
  input  logic       moon_on,
  input  logic       hit_ack,
  input  logic       restart,
  output logic       hit,
  output logic [2:0] lives,
  output logic       invuln,
  output logic       flash,
  output logic       game_over,
  output logic [7:0] overlap_last
);
  import moon_collision_pkg::*;

  localparam logic [CNT_W-1:0]   HIT_TH   = CNT_W'(HIT_PIXELS);
  localparam logic [7:0]         INV_LOAD = 8'(INVULN_FRAMES);
  localparam logic [LIVES_W-1:0] LIVES_LD = LIVES_W'(LIVES_INIT);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [7:0]       inv_cnt;
  logic [3:0]       blink_cnt;
  logic             eval_hit;
  logic             new_game;
  logic             hit_nxt;
  logic             invuln_nxt;
  logic             game_over_nxt;

  // Restart only means something once the game is over.
  assign new_game = (state == DEAD) && restart;

  // Frame evaluation; lives != 0 keeps the counter from wrapping.
  assign eval_hit = (state == ALIVE) && frame_tick && (count >= HIT_TH) && (lives != '0);

  moon_collision_overlap_counter #(
    .MAX_X (MAX_X),
    .MAX_Y (MAX_Y)
  ) u_overlap_counter (
    .clk          (clk),
    .reset        (reset),
    .pixel_tick   (pixel_tick),
    .frame_tick   (frame_tick),
    .clear        (new_game),
    .x            (x),
    .y            (y),
    .player_on    (player_on),
    .moon_on      (moon_on),
    .count        (count),
    .overlap_last (overlap_last)
  );

  // State register, with the state-decoded outputs registered alongside.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ALIVE;
      hit       <= 1'b0;
      invuln    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      hit       <= hit_nxt;
      invuln    <= invuln_nxt;
      game_over <= game_over_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ALIVE: begin
        if (eval_hit) state_nxt = HIT_WAIT;
      end
      HIT_WAIT: begin
        // lives was already decremented when the hit was raised.
        if (hit_ack) state_nxt = (lives == '0) ? DEAD : INVULN;
      end
      INVULN: begin
        // The frame_tick that takes the window to zero ends it.
        if (frame_tick && (inv_cnt <= 8'd1)) state_nxt = ALIVE;
      end
      DEAD: begin
        if (restart) state_nxt = ALIVE;
      end
      default: state_nxt = ALIVE;
    endcase
  end

  // Output logic: values the registered outputs take in the next state.
  always_comb begin
    hit_nxt       = (state_nxt == HIT_WAIT);
    invuln_nxt    = (state_nxt == INVULN);
    game_over_nxt = (state_nxt == DEAD);
  end

  // Lives, invulnerability window and blink counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lives     <= LIVES_LD;
      inv_cnt   <= '0;
      blink_cnt <= '0;
    end else begin
      case (state)
        ALIVE: begin
          if (eval_hit) lives <= lives - 3'd1;
        end
        HIT_WAIT: begin
          // An ack on a frame_tick loads the full window; that tick is not counted.
          if (hit_ack && (lives != '0)) inv_cnt <= INV_LOAD;
        end
        INVULN: begin
          if (frame_tick) begin
            if (inv_cnt != '0) inv_cnt <= inv_cnt - 8'd1;
            blink_cnt <= blink_cnt + 4'd1;
          end
        end
        DEAD: begin
          if (restart) begin
            lives     <= LIVES_LD;
            inv_cnt   <= '0;
            blink_cnt <= '0;
          end
        end
        default: begin
          lives <= lives;
        end
      endcase
    end
  end

  assign flash = invuln & blink_cnt[3];

endmodule

// File: tb/tb_moon_collision.sv
module tb_moon_collision;

  logic       clk;
  logic       reset;
  logic       pixel_tick;
  logic       frame_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       player_on;
  logic       moon_on;
  logic       hit_ack;
  logic       restart;
  logic       hit;
  logic [2:0] lives;
  logic       invuln;
  logic       flash;
  logic       game_over;
  logic [7:0] overlap_last;

  int checks = 0;
  int errors = 0;

  // Reference model: game described as counts and flags, updated per clock edge.
  int m_lives, m_inv_left, m_blink, m_cnt, m_last;
  bit m_hit, m_dead;

  moon_collision dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_tick   (pixel_tick),
    .frame_tick   (frame_tick),
    .x            (x),
    .y            (y),
    .player_on    (player_on),
    .moon_on      (moon_on),
    .hit_ack      (hit_ack),
    .restart      (restart),
    .hit          (hit),
    .lives        (lives),
    .invuln       (invuln),
    .flash        (flash),
    .game_over    (game_over),
    .overlap_last (overlap_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit m_invuln;
    m_invuln = (m_inv_left > 0);
    chk({tag, "_hit"},       32'(hit),          32'(m_hit));
    chk({tag, "_lives"},     32'(lives),        32'(m_lives));
    chk({tag, "_invuln"},    32'(invuln),       32'(m_invuln));
    chk({tag, "_flash"},     32'(flash),        32'(m_invuln && (m_blink >= 8)));
    chk({tag, "_game_over"}, 32'(game_over),    32'(m_dead));
    chk({tag, "_last"},      32'(overlap_last), 32'(m_last));
  endtask

  function automatic bit qualifies(bit pt, int xx, int yy, bit p, bit m);
    return pt && p && m && (xx < 384) && (yy < 448);
  endfunction

  task automatic model_reset();
    m_lives = 3; m_inv_left = 0; m_blink = 0; m_cnt = 0; m_last = 0;
    m_hit = 0; m_dead = 0;
  endtask

  // One clock cycle with the given inputs; the model follows the game rules.
  task automatic cyc(input bit pt, input int xx, input int yy, input bit p, input bit m,
                     input bit ft, input bit ack, input bit rs);
    bit q, hit_was, dead_was;
    int inv_was;
    pixel_tick = pt; x = 10'(xx); y = 10'(yy); player_on = p; moon_on = m;
    frame_tick = ft; hit_ack = ack; restart = rs;
    @(posedge clk);
    q = qualifies(pt, xx, yy, p, m);
    hit_was = m_hit; dead_was = m_dead; inv_was = m_inv_left;
    if (ft) begin
      m_last = m_cnt;
      if (!dead_was && !hit_was && inv_was == 0) begin
        if (m_last >= 4 && m_lives >= 1) begin
          m_hit = 1;
          m_lives = m_lives - 1;
        end
      end else if (inv_was > 0) begin
        m_inv_left = m_inv_left - 1;
        m_blink = (m_blink + 1) % 16;
      end
    end
    if (rs && dead_was) m_cnt = 0;
    else if (ft) m_cnt = q ? 1 : 0;
    else if (q) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    if (ack && hit_was) begin
      m_hit = 0;
      if (m_lives == 0) m_dead = 1;
      else m_inv_left = 120;
    end
    if (rs && dead_was) begin
      m_lives = 3; m_dead = 0; m_blink = 0; m_inv_left = 0;
    end
    #1;
    pixel_tick = 0; frame_tick = 0; hit_ack = 0; restart = 0;
  endtask

  task automatic idle(input bit ack, input bit rs);
    cyc(0, 0, 0, 0, 0, 0, ack, rs);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      pixel_tick = 1; x = 10'd10; y = 10'd10; player_on = 1; moon_on = 1;
      frame_tick = (i == 0); hit_ack = 0; restart = 0;
      @(posedge clk);
      #1;
    end
    model_reset();
    reset = 1'b1;
    pixel_tick = 0; frame_tick = 0;
  endtask

  // A frame of n_ovl overlapping pixels (in range, or on the exact boundary when oor)
  // interleaved with n_noise non-qualifying pixels, closed by frame_tick.
  task automatic frame(input int n_ovl, input int n_noise, input bit oor,
                       input bit ft_px, input bit ack_at_ft);
    int ro, rn, kind, xx, yy;
    ro = n_ovl; rn = n_noise;
    while (ro + rn > 0) begin
      if (ro > 0 && (rn == 0 || $urandom_range(0, ro + rn - 1) < ro)) begin
        ro--;
        if (!oor) cyc(1, $urandom_range(0, 383), $urandom_range(0, 447), 1, 1, 0, 0, 0);
        else if ($urandom_range(0, 1) == 1) cyc(1, 384, $urandom_range(0, 447), 1, 1, 0, 0, 0);
        else cyc(1, $urandom_range(0, 383), 448, 1, 1, 0, 0, 0);
      end else begin
        rn--;
        kind = $urandom_range(0, 2);
        xx = $urandom_range(0, 383); yy = $urandom_range(0, 447);
        cyc(kind != 0, xx, yy, kind != 1, kind != 2, 0, 0, 0);
      end
    end
    cyc(ft_px, $urandom_range(0, 383), $urandom_range(0, 447), 1, 1, 1, ack_at_ft, 0);
  endtask

  initial begin
    int n;
    reset = 0; pixel_tick = 0; frame_tick = 0; x = '0; y = '0;
    player_on = 0; moon_on = 0; hit_ack = 0; restart = 0;
    model_reset();

    // Reset state (pixels and a frame_tick presented during reset are ignored).
    do_reset(3);
    check_all("reset");
    chk("reset_lives", 32'(lives), 32'd3);
    chk("reset_last", 32'(overlap_last), 32'd0);
    idle(0, 0);

    // Below threshold.
    frame(3, 5, 0, 0, 0);
    check_all("f3");
    chk("f3_hit", 32'(hit), 32'd0);
    chk("f3_last", 32'(overlap_last), 32'd3);

    // Hit from 10 overlaps.
    frame(10, 8, 0, 0, 0);
    check_all("f10");
    chk("f10_hit", 32'(hit), 32'd1);
    chk("f10_lives", 32'(lives), 32'd2);
    chk("f10_last", 32'(overlap_last), 32'd10);

    // Hit held; restart ignored outside DEAD.
    idle(0, 1);
    idle(0, 0);
    check_all("hold");

    // Acknowledge, then a stray ack outside HIT_WAIT.
    idle(1, 0);
    check_all("ack1");
    chk("ack1_invuln", 32'(invuln), 32'd1);
    idle(1, 0);
    check_all("stray_ack");

    // Invulnerability window with 50 overlaps per frame.
    n = 0;
    for (int i = 0; i < 130 && invuln === 1'b1; i++) begin
      frame(50, 4, 0, (i % 3) == 0, 0);
      n++;
      check_all("inv_a");
    end
    chk("inv_a_len", 32'(n), 32'd120);
    frame(50, 2, 0, 0, 0);
    check_all("hit2");
    chk("hit2_lives", 32'(lives), 32'd1);

    // Ack coincident with frame_tick: the window is still a full 120 frames.
    idle(0, 0);
    frame(0, 3, 0, 0, 1);
    check_all("ack_ft");
    n = 0;
    for (int i = 0; i < 130 && invuln === 1'b1; i++) begin
      frame(2, 2, 0, 0, 0);
      n++;
      check_all("inv_b");
    end
    chk("inv_b_len", 32'(n), 32'd120);

    // Third hit, game over.
    frame(6, 0, 0, 0, 0);
    check_all("hit3");
    chk("hit3_lives", 32'(lives), 32'd0);
    idle(1, 0);
    check_all("dead");
    chk("dead_go", 32'(game_over), 32'd1);
    frame(20, 3, 0, 0, 0);
    idle(1, 0);
    check_all("dead_idle");
    idle(0, 1);
    check_all("restart");
    chk("restart_lives", 32'(lives), 32'd3);
    chk("restart_go", 32'(game_over), 32'd0);

    // Boundary pixels never count; then saturation.
    frame(600, 0, 1, 0, 0);
    check_all("oor");
    chk("oor_last", 32'(overlap_last), 32'd0);
    frame(300, 10, 0, 0, 0);
    check_all("sat");
    chk("sat_last", 32'(overlap_last), 32'd255);
    chk("sat_hit", 32'(hit), 32'd1);

    // Reset in the middle of a handshake.
    do_reset(1);
    check_all("mid_reset");
    chk("mid_reset_hit", 32'(hit), 32'd0);
    chk("mid_reset_lives", 32'(lives), 32'd3);

    // Randomized frames with random acks and restarts.
    for (int i = 0; i < 60; i++) begin
      for (int j = 0; j < $urandom_range(0, 2); j++)
        idle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      frame($urandom_range(0, 8), $urandom_range(0, 6), 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/moon_collision.md
Name: moon_collision

Overview:
- Consumer of the moon sprite's per-pixel coverage output.
- Compares `moon_on` against the player sprite's coverage on every drawn pixel and accumulates the overlap count over one video frame.
- Converts the per-frame overlap count into a hit event with a request/acknowledge handshake toward the game-control logic.
- Owns the player lives counter, the post-hit invulnerability window and the game-over state.

Parameters:
- LIVES_INIT, 3: lives loaded at reset and on restart (1..7).
- INVULN_FRAMES, 120: frames of invulnerability after an acknowledged hit (1..255).
- HIT_PIXELS, 4: minimum overlapping pixels in one frame that count as a hit (1..255).
- MAX_X, 384: playfield width; pixels with x >= MAX_X are ignored.
- MAX_Y, 448: playfield height; pixels with y >= MAX_Y are ignored.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- pixel_tick  in  1  qualifies x/y/player_on/moon_on as a valid drawn pixel this cycle
- frame_tick  in  1  single-cycle pulse once per frame, at start of vertical blank
- x  in  10  current pixel column
- y  in  10  current pixel row
- player_on  in  1  player sprite covers pixel (x,y)
- moon_on  in  1  moon sprite covers pixel (x,y)
- hit_ack  in  1  game control acknowledges a pending hit
- restart  in  1  leave DEAD and start a new game
- hit  out  1  hit request, level, held until acknowledged
- lives  out  3  remaining lives
- invuln  out  1  invulnerability window active
- flash  out  1  player blink enable: invuln AND blink_cnt[3]
- game_over  out  1  high in DEAD
- overlap_last  out  8  overlap count of the last completed frame

Behaviour:
- Reset (reset==0 at a clk edge) sets the following, overriding everything including mid-handshake:
  - state=ALIVE, lives=LIVES_INIT, hit=0, invuln=0, flash=0, game_over=0
  - overlap_last=0, overlap counter=0, invuln counter=0, blink_cnt=0
- Overlap counter (8 bit):
  - Increments on a cycle with pixel_tick && player_on && moon_on && x<MAX_X && y<MAX_Y.
  - Saturates at 255.
  - Counts in every state; only the evaluation is state-gated.
- On frame_tick:
  - overlap_last <= counter value.
  - The counter loads 1 if this cycle also qualifies an overlapping pixel, else 0; that pixel belongs to the new frame.
- States:
  - ALIVE: on frame_tick, if counter >= HIT_PIXELS, go to HIT_WAIT, hit<=1, lives<=lives-1 (registered, visible next cycle).
  - HIT_WAIT:
    - hit=1 and overlaps are not evaluated.
    - On hit_ack: hit<=0. If lives==0, go to DEAD; else go to INVULN and load the invuln counter with INVULN_FRAMES.
    - hit_ack and frame_tick in the same cycle: the ack is taken; that frame_tick does not decrement the freshly loaded counter.
  - INVULN:
    - invuln=1 and overlaps are not evaluated.
    - Each frame_tick decrements the invuln counter and increments blink_cnt (4 bit, wraps).
    - The frame_tick that makes the counter 0 moves the state to ALIVE the next cycle. The first evaluation in ALIVE happens at the following frame_tick, with the counter freshly cleared.
  - DEAD:
    - game_over=1, hit=0, lives=0.
    - restart loads lives=LIVES_INIT, clears invuln, blink_cnt and the overlap counter, and moves the state to ALIVE.
    - restart in any other state is ignored.
- Handshake and latency:
  - hit_ack outside HIT_WAIT is ignored.
  - hit rises the cycle after the evaluating frame_tick and falls the cycle after hit_ack.
- Arithmetic:
  - All comparisons are unsigned.
  - lives never wraps below 0; a hit is only possible with lives >= 1.
- Outputs are registered except flash, which is a single AND of registers.

Decomposition:
- Shared game package holds:
  - playfield constants MAX_X=384 and MAX_Y=448 (shared with the sprite blocks)
  - the 2-bit state encoding: ALIVE, HIT_WAIT, INVULN, DEAD
  - the lives width constant
- One natural sub-module: overlap_counter, covering the saturating per-frame pixel counter plus the overlap_last latch.
- The FSM, lives, invuln counter and blink logic stay in moon_collision.

Test Plan:
- Reset with 10 overlapping pixels in the frame, then frame_tick -> the following hold:
  - hit rises 1 cycle later
  - lives 3->2
  - overlap_last=10
  - hit_ack -> hit=0, invuln=1, invuln counter=120
- 3 overlapping pixels (< HIT_PIXELS=4), then frame_tick -> hit stays 0, lives=3, overlap_last=3.
- From INVULN, drive 120 frame_ticks, each frame with 50 overlaps -> the following hold:
  - no hit during the window
  - invuln falls after the 120th tick
  - the next frame with 50 overlaps produces a hit and lives=1
- Three acknowledged hits -> the following hold:
  - lives=0 and DEAD, game_over=1
  - restart -> lives=3, game_over=0, state ALIVE
- Overlaps only at x=384 or y=448 (600 pixels) -> overlap_last=0, no hit. 300 valid overlaps -> overlap_last=255 (saturated).
- Mid-handshake cases:
  - reset pulled low while hit=1 -> next cycle hit=0, lives=3.
  - hit_ack coincident with frame_tick in HIT_WAIT -> invuln counter reads 120, not 119.
